// File: rtl/lcd_pkg.sv
// Shared definitions for the Wishbone LCD controller.
// Contents: register map, writer FSM states and STATUS bit layout.
package lcd_pkg;

  localparam logic [1:0] LCD_REG_CMD    = 2'd0;
  localparam logic [1:0] LCD_REG_DATA   = 2'd1;
  localparam logic [1:0] LCD_REG_STATUS = 2'd2;
  localparam logic [1:0] LCD_REG_CTRL   = 2'd3;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_WR_LOW,
    ST_WR_HIGH
  } lcd_state_e;

  // STATUS = {busy, full, empty, init_done, level[3:0]}
  localparam int STAT_BUSY      = 7;
  localparam int STAT_FULL      = 6;
  localparam int STAT_EMPTY     = 5;
  localparam int STAT_INIT_DONE = 4;
  localparam int STAT_LEVEL_MSB = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port, occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/wb_lcd_ctrl.sv
// Wishbone register slave that queues LCD command/data bytes and plays them out
// on an 8080-style write strobe after a power-on LCD reset sequence.
module wb_lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int WR_LOW_CYCLES   = 2,
  parameter int WR_HIGH_CYCLES  = 2,
  parameter int RST_LOW_CYCLES  = 1024,
  parameter int RST_WAIT_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  output logic [7:0] dat_o,
  output logic       lcd_nreset,
  output logic       lcd_cmd_data,
  output logic       lcd_write_edge,
  output logic [7:0] lcd_dout,
  output logic       lcd_backlight
);

  localparam int MAX_CYC = max_int(max_int(WR_LOW_CYCLES, WR_HIGH_CYCLES),
                                   max_int(RST_LOW_CYCLES, RST_WAIT_CYCLES));
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int LVL_W   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOW_LAST   = CNT_W'(WR_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_LAST  = CNT_W'(WR_HIGH_CYCLES - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nreset_q, nreset_d;
  logic             edge_q, edge_d;
  logic [7:0]       dout_q, dout_d;
  logic             cd_q, cd_d;
  logic             init_done_q, init_done_d;
  logic             ack_q, ack_d;
  logic [7:0]       dat_q, dat_d;
  logic             backlight_q, backlight_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [8:0]       fifo_din, fifo_dout;
  logic [LVL_W-1:0] fifo_level;
  logic             is_fifo_reg, stall, ctrl_wr, restart;
  logic [3:0]       level_sat;
  logic [7:0]       status;

  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (restart),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Stall uses the registered full flag, so a pop only frees the slot next cycle.
  assign is_fifo_reg = (adr_i == LCD_REG_CMD) || (adr_i == LCD_REG_DATA);
  assign stall       = stb_i && we_i && is_fifo_reg && fifo_full;
  assign ack_d       = stb_i && !ack_q && !stall;
  assign fifo_push   = ack_d && we_i && is_fifo_reg;
  assign fifo_din    = {(adr_i == LCD_REG_DATA), dat_i};
  assign ctrl_wr     = ack_d && we_i && (adr_i == LCD_REG_CTRL);
  assign restart     = ctrl_wr && dat_i[1];

  always_comb begin
    level_sat = (int'(fifo_level) > 15) ? 4'd15 : 4'(fifo_level);
    status                        = '0;
    status[STAT_BUSY]             = (state_q != ST_IDLE) || !fifo_empty;
    status[STAT_FULL]             = fifo_full;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_INIT_DONE]        = init_done_q;
    status[STAT_LEVEL_MSB:0]      = level_sat;
  end

  always_comb begin
    dat_d       = dat_q;
    backlight_d = backlight_q;
    if (ack_d && !we_i) begin
      case (adr_i)
        LCD_REG_STATUS: dat_d = status;
        LCD_REG_CTRL:   dat_d = {7'd0, backlight_q};
        default:        dat_d = '0;
      endcase
    end
    if (ctrl_wr) backlight_d = dat_i[0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    nreset_d    = nreset_q;
    edge_d      = edge_q;
    dout_d      = dout_q;
    cd_d        = cd_q;
    init_done_d = init_done_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_RST_LOW: begin
        nreset_d = 1'b0;
        if (cnt_q == RST_LOW_LAST) begin
          state_d  = ST_RST_WAIT;
          cnt_d    = '0;
          nreset_d = 1'b1;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == RST_WAIT_LAST) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dout_d   = fifo_dout[7:0];
          cd_d     = fifo_dout[8];
          edge_d   = 1'b0;
          state_d  = ST_WR_LOW;
        end
      end
      ST_WR_LOW: begin
        if (cnt_q == WR_LOW_LAST) begin
          edge_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_WR_HIGH;
        end
      end
      ST_WR_HIGH: begin
        if (cnt_q == WR_HIGH_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            dout_d   = fifo_dout[7:0];
            cd_d     = fifo_dout[8];
            edge_d   = 1'b0;
            state_d  = ST_WR_LOW;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_RST_LOW;
        cnt_d   = '0;
      end
    endcase
    // A restart abandons any byte in flight and replays the LCD reset.
    if (restart) begin
      state_d     = ST_RST_LOW;
      cnt_d       = '0;
      nreset_d    = 1'b0;
      edge_d      = 1'b1;
      init_done_d = 1'b0;
      fifo_pop    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RST_LOW;
      cnt_q       <= '0;
      nreset_q    <= 1'b0;
      edge_q      <= 1'b1;
      dout_q      <= '0;
      cd_q        <= 1'b0;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      backlight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nreset_q    <= nreset_d;
      edge_q      <= edge_d;
      dout_q      <= dout_d;
      cd_q        <= cd_d;
      init_done_q <= init_done_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      backlight_q <= backlight_d;
    end
  end

  assign ack_o          = ack_q;
  assign dat_o          = dat_q;
  assign lcd_nreset     = nreset_q;
  assign lcd_cmd_data   = cd_q;
  assign lcd_write_edge = edge_q;
  assign lcd_dout       = dout_q;
  assign lcd_backlight  = backlight_q;

endmodule

// File: tb/tb_wb_lcd_ctrl.sv
// Directed bench for wb_lcd_ctrl: register vector table plus hand-timed init,
// burst, stall, restart and async-reset sequences against the default parameters.
module tb_wb_lcd_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       stb_i = 1'b0;
  logic       we_i = 1'b0;
  logic [1:0] adr_i = 2'd0;
  logic [7:0] dat_i = 8'd0;
  logic       ack_o;
  logic [7:0] dat_o;
  logic       lcd_nreset, lcd_cmd_data, lcd_write_edge, lcd_backlight;
  logic [7:0] lcd_dout;

  wb_lcd_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .stb_i          (stb_i),
    .we_i           (we_i),
    .adr_i          (adr_i),
    .dat_i          (dat_i),
    .ack_o          (ack_o),
    .dat_o          (dat_o),
    .lcd_nreset     (lcd_nreset),
    .lcd_cmd_data   (lcd_cmd_data),
    .lcd_write_edge (lcd_write_edge),
    .lcd_dout       (lcd_dout),
    .lcd_backlight  (lcd_backlight)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] wdat;
    logic [7:0] exp_rd;
    logic       exp_bl;
  } vec_t;

  typedef struct {
    logic       cd;
    logic [7:0] d;
    int         cyc;
  } cap_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;
  int   first_fall = -1;
  cap_t cap_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Capture each LCD byte on a rising write_edge while the LCD is out of reset.
  initial begin
    logic       prev_we;
    logic [8:0] low_val;
    logic       low_dirty;
    prev_we   = 1'b1;
    low_val   = '0;
    low_dirty = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (!prev_we && lcd_write_edge && lcd_nreset) begin
        check("dout_stable", low_dirty, 0);
        cap_q.push_back('{cd: lcd_cmd_data, d: lcd_dout, cyc: cyc});
        $display("lcd byte cd=%0d d=0x%02h cyc=%0d", lcd_cmd_data, lcd_dout, cyc);
      end
      if (prev_we && !lcd_write_edge) begin
        low_val   = {lcd_cmd_data, lcd_dout};
        low_dirty = 1'b0;
        if (first_fall < 0) first_fall = cyc;
      end else if (!lcd_write_edge && ({lcd_cmd_data, lcd_dout} != low_val)) begin
        low_dirty = 1'b1;
      end
      prev_we = lcd_write_edge;
    end
  end

  task automatic bus(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                     input int budget, output logic [7:0] rd, output int waits);
    stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; waits = 0;
    while (1) begin
      @(posedge clk_i); #1;
      waits++;
      if (ack_o || waits >= budget) break;
    end
    if (!ack_o) check("ack_timeout", 0, 1);
    rd = dat_o;
    last_ack_cyc = cyc;
    stb_i = 1'b0; we_i = 1'b0;
    $display("bus we=%0d adr=%0d wdat=0x%02h rdat=0x%02h waits=%0d cyc=%0d", we, adr, wd, rd, waits, cyc);
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [1:0] adr, input logic [7:0] wd);
    logic [7:0] r;
    int w;
    bus(1'b1, adr, wd, 100, r, w);
    check("wr_ack_wait", w, 1);
  endtask

  task automatic rd(input logic [1:0] adr, input logic [7:0] exp, input string name);
    logic [7:0] r;
    int w;
    bus(1'b0, adr, 8'h00, 100, r, w);
    check("rd_ack_wait", w, 1);
    check(name, r, exp);
  endtask

  task automatic wait_nreset(output int rise_cyc);
    int n;
    n = 0;
    while (!lcd_nreset && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!lcd_nreset) check("nreset_timeout", 0, 1);
    rise_cyc = cyc;
  endtask

  task automatic wait_caps(input int n, input int budget);
    int k;
    k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (cap_q.size() < n) check("cap_timeout", cap_q.size(), n);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, ack_o, 0);
    check({tag, "_dat"}, dat_o, 0);
    check({tag, "_nreset"}, lcd_nreset, 0);
    check({tag, "_cd"}, lcd_cmd_data, 0);
    check({tag, "_edge"}, lcd_write_edge, 1);
    check({tag, "_dout"}, lcd_dout, 0);
    check({tag, "_bl"}, lcd_backlight, 0);
  endtask

  initial begin
    vec_t       vecs[9];
    logic [7:0] rdv;
    int         w, c0, rise, a, r, acks;

    vecs[0] = '{we: 1'b0, adr: 2'd2, wdat: 8'h00, exp_rd: 8'h30, exp_bl: 1'b0};
    vecs[1] = '{we: 1'b1, adr: 2'd3, wdat: 8'h01, exp_rd: 8'h00, exp_bl: 1'b1};
    vecs[2] = '{we: 1'b0, adr: 2'd3, wdat: 8'h00, exp_rd: 8'h01, exp_bl: 1'b1};
    vecs[3] = '{we: 1'b0, adr: 2'd0, wdat: 8'h00, exp_rd: 8'h00, exp_bl: 1'b1};
    vecs[4] = '{we: 1'b0, adr: 2'd1, wdat: 8'h00, exp_rd: 8'h00, exp_bl: 1'b1};
    vecs[5] = '{we: 1'b1, adr: 2'd2, wdat: 8'hFF, exp_rd: 8'h00, exp_bl: 1'b1};
    vecs[6] = '{we: 1'b0, adr: 2'd2, wdat: 8'h00, exp_rd: 8'h30, exp_bl: 1'b1};
    vecs[7] = '{we: 1'b1, adr: 2'd3, wdat: 8'h00, exp_rd: 8'h00, exp_bl: 1'b0};
    vecs[8] = '{we: 1'b0, adr: 2'd3, wdat: 8'h00, exp_rd: 8'h00, exp_bl: 1'b0};

    // Power-on reset and init; three bytes queued during RST_WAIT.
    #2 rst_ni = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) @(posedge clk_i);
    #4 rst_ni = 1'b1;
    c0 = cyc;
    wait_nreset(rise);
    check("rst_low_len", rise - c0, 1024);
    wr(2'd1, 8'h11);
    wr(2'd0, 8'h12);
    wr(2'd1, 8'h13);
    repeat (4089) @(posedge clk_i);
    #1;
    rd(2'd2, 8'h83, "status_pre_init");
    check("no_early_bytes", cap_q.size(), 0);
    rd(2'd2, 8'h92, "status_post_init");
    wait_caps(3, 100);
    if (cap_q.size() >= 3) begin
      check("init_b0_cd", cap_q[0].cd, 1);
      check("init_b0_d", cap_q[0].d, 8'h11);
      check("init_b1_cd", cap_q[1].cd, 0);
      check("init_b1_d", cap_q[1].d, 8'h12);
      check("init_b2_cd", cap_q[2].cd, 1);
      check("init_b2_d", cap_q[2].d, 8'h13);
      check("init_first_edge", cap_q[0].cyc - rise, 4099);
      check("init_gap1", cap_q[1].cyc - cap_q[0].cyc, 4);
      check("init_gap2", cap_q[2].cyc - cap_q[1].cyc, 4);
    end
    repeat (8) @(posedge clk_i);
    #1;

    // Register vector table.
    for (int i = 0; i < 9; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].wdat, 100, rdv, w);
      check($sformatf("vec%0d_ack_wait", i), w, 1);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rdv, vecs[i].exp_rd);
      check($sformatf("vec%0d_bl", i), lcd_backlight, vecs[i].exp_bl);
    end

    // Strobe held for four cycles: ack must pulse every other cycle.
    acks = 0;
    stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd3;
    repeat (4) begin
      @(posedge clk_i); #1;
      acks += int'(ack_o);
    end
    stb_i = 1'b0;
    @(posedge clk_i); #1;
    check("held_stb_acks", acks, 2);

    // CMD 0x2A then DATA 0x55.
    cap_q.delete();
    wr(2'd0, 8'h2A);
    a = last_ack_cyc;
    wr(2'd1, 8'h55);
    wait_caps(2, 50);
    if (cap_q.size() >= 2) begin
      check("pair_b0_cd", cap_q[0].cd, 0);
      check("pair_b0_d", cap_q[0].d, 8'h2A);
      check("pair_b1_cd", cap_q[1].cd, 1);
      check("pair_b1_d", cap_q[1].d, 8'h55);
      check("pair_latency", cap_q[0].cyc - a, 3);
      check("pair_gap", cap_q[1].cyc - cap_q[0].cyc, 4);
    end
    repeat (10) @(posedge clk_i);
    #1;

    // Restart via CTRL=0x03 in the middle of a burst.
    cap_q.delete();
    wr(2'd1, 8'hA0);
    wr(2'd1, 8'hA1);
    wr(2'd1, 8'hA2);
    check("nreset_before_restart", lcd_nreset, 1);
    wr(2'd3, 8'h03);
    r = last_ack_cyc;
    check("restart_nreset", lcd_nreset, 0);
    check("restart_edge", lcd_write_edge, 1);
    check("restart_bl", lcd_backlight, 1);
    rd(2'd2, 8'hA0, "restart_status");
    rd(2'd3, 8'h01, "restart_ctrl");
    check("restart_caps", cap_q.size(), 1);
    if (cap_q.size() >= 1) check("restart_b0_d", cap_q[0].d, 8'hA0);
    wait_nreset(rise);
    check("restart_low_len", rise - r, 1024);

    // Seventeen DATA bytes during RST_WAIT: the last one stalls until the first pop.
    cap_q.delete();
    first_fall = -1;
    for (int i = 0; i < 16; i++) wr(2'd1, 8'(8'h40 + i));
    rd(2'd2, 8'hCF, "status_full");
    bus(1'b1, 2'd1, 8'h50, 6000, rdv, w);
    check("ack17_delayed", int'(w > 1), 1);
    check("ack17_after_pop", last_ack_cyc - first_fall, 1);
    wait_caps(17, 200);
    repeat (20) @(posedge clk_i);
    #1;
    check("burst_count", cap_q.size(), 17);
    if (cap_q.size() >= 17) begin
      for (int i = 0; i < 17; i++) begin
        check($sformatf("burst_d%0d", i), cap_q[i].d, (i < 16) ? (8'h40 + i) : 8'h50);
        check($sformatf("burst_cd%0d", i), cap_q[i].cd, 1);
        if (i > 0) check($sformatf("burst_gap%0d", i), cap_q[i].cyc - cap_q[i-1].cyc, 4);
      end
    end

    // Asynchronous reset while a byte is in its low phase.
    wr(2'd1, 8'h77);
    w = 0;
    while (lcd_write_edge && w < 20) begin
      @(posedge clk_i); #1;
      w++;
    end
    check("in_wr_low", lcd_write_edge, 0);
    #3 rst_ni = 1'b0;
    #1 check_reset_vals("async");
    cap_q.delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #4 rst_ni = 1'b1;
    c0 = cyc;
    wait_nreset(rise);
    check("rerun_low_len", rise - c0, 1024);
    repeat (4095) @(posedge clk_i);
    #1;
    rd(2'd2, 8'hA0, "rerun_status_pre");
    rd(2'd2, 8'h30, "rerun_status_post");
    check("rerun_no_bytes", cap_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
